// File: rtl/carrd_wb_pkg.sv
// Shared types for the writeback commit slice: the queued write entry and
// the lane packing that forms a full vector register from four 128-bit lanes.
package carrd_wb_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 128;

    typedef struct packed {
        logic                          is_x;
        logic [4:0]                    addr;
        logic [NUM_LANES*LANE_W-1:0]   data;
    } wb_entry_t;

    function automatic logic [NUM_LANES*LANE_W-1:0] lane_pack(
        input logic [LANE_W-1:0] l0,
        input logic [LANE_W-1:0] l1,
        input logic [LANE_W-1:0] l2,
        input logic [LANE_W-1:0] l3
    );
        return {l3, l2, l1, l0};
    endfunction

endpackage

// File: rtl/carrd_wb_commit_if.sv
// Bundle of writeback, issue-check and register-file write signals around
// the commit block; slave is the commit block, master is its environment.
interface carrd_wb_commit_if;
    import carrd_wb_pkg::*;

    logic                          v_reg_wr_en;
    logic                          x_reg_wr_en;
    logic [4:0]                    reg_wr_addr;
    logic [LANE_W-1:0]             reg_wr_data;
    logic [LANE_W-1:0]             reg_wr_data_2;
    logic [LANE_W-1:0]             reg_wr_data_3;
    logic [LANE_W-1:0]             reg_wr_data_4;
    logic                          issue_valid;
    logic [4:0]                    issue_rd;
    logic                          issue_rd_is_x;
    logic [4:0]                    chk_vs1;
    logic [4:0]                    chk_vs2;
    logic [4:0]                    chk_vd;
    logic [4:0]                    chk_xs1;
    logic                          vrf_ready;
    logic                          vrf_wr_en;
    logic [4:0]                    vrf_wr_addr;
    logic [NUM_LANES*LANE_W-1:0]   vrf_wr_data;
    logic                          xrf_wr_en;
    logic [4:0]                    xrf_wr_addr;
    logic [31:0]                   xrf_wr_data;
    logic                          issue_stall;
    logic [31:0]                   v_busy;
    logic [31:0]                   x_busy;
    logic                          wb_overflow;

    modport slave (
        input  v_reg_wr_en, x_reg_wr_en, reg_wr_addr,
               reg_wr_data, reg_wr_data_2, reg_wr_data_3, reg_wr_data_4,
               issue_valid, issue_rd, issue_rd_is_x,
               chk_vs1, chk_vs2, chk_vd, chk_xs1, vrf_ready,
        output vrf_wr_en, vrf_wr_addr, vrf_wr_data,
               xrf_wr_en, xrf_wr_addr, xrf_wr_data,
               issue_stall, v_busy, x_busy, wb_overflow
    );

    modport master (
        output v_reg_wr_en, x_reg_wr_en, reg_wr_addr,
               reg_wr_data, reg_wr_data_2, reg_wr_data_3, reg_wr_data_4,
               issue_valid, issue_rd, issue_rd_is_x,
               chk_vs1, chk_vs2, chk_vd, chk_xs1, vrf_ready,
        input  vrf_wr_en, vrf_wr_addr, vrf_wr_data,
               xrf_wr_en, xrf_wr_addr, xrf_wr_data,
               issue_stall, v_busy, x_busy, wb_overflow
    );

endinterface

// File: rtl/carrd_wb_fifo.sv
// Commit FIFO of writeback entries. A push at full is accepted only when a
// pop frees the slot in the same cycle; otherwise it is ignored here.
module carrd_wb_fifo
    import carrd_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t          mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset: occupancy is governed by count alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/carrd_wb_commit.sv
// Writeback commit: one-shot capture of level writeback enables, in-order
// drain to VRF/XRF through a small FIFO, and the destination scoreboard.
module carrd_wb_commit
    import carrd_wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int NREGS  = 32,
    parameter int VLEN_W = 512
) (
    input  logic               clk,
    input  logic               rst,
    carrd_wb_commit_if.slave   bus
);

    logic               prev_en;
    logic [4:0]         prev_addr;
    logic               cur_en;
    logic               capture;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    wb_entry_t          push_entry;
    wb_entry_t          head;
    logic [VLEN_W-1:0]  head_data;
    logic [NREGS-1:0]   v_busy;
    logic [NREGS-1:0]   x_busy;
    logic [NREGS-1:0]   v_set;
    logic [NREGS-1:0]   x_set;
    logic [NREGS-1:0]   v_clr;
    logic [NREGS-1:0]   x_clr;
    logic               wb_overflow;

    // A held enable only counts again once the destination changes.
    assign cur_en  = bus.v_reg_wr_en | bus.x_reg_wr_en;
    assign capture = cur_en & (~prev_en | (bus.reg_wr_addr != prev_addr));

    always_comb begin
        push_entry.is_x = ~bus.v_reg_wr_en;
        push_entry.addr = bus.reg_wr_addr;
        push_entry.data = lane_pack(bus.reg_wr_data, bus.reg_wr_data_2,
                                    bus.reg_wr_data_3, bus.reg_wr_data_4);
    end

    carrd_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (capture),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_data       = head.data;
    assign pop             = ~fifo_empty & (head.is_x | bus.vrf_ready);
    assign bus.vrf_wr_en   = ~fifo_empty & ~head.is_x;
    assign bus.vrf_wr_addr = head.addr;
    assign bus.vrf_wr_data = head_data;
    assign bus.xrf_wr_en   = ~fifo_empty & head.is_x;
    assign bus.xrf_wr_addr = head.addr;
    assign bus.xrf_wr_data = head_data[31:0];

    always_comb begin
        v_set = '0;
        x_set = '0;
        v_clr = '0;
        x_clr = '0;
        for (int i = 0; i < NREGS; i++) begin
            v_set[i] = bus.issue_valid & ~bus.issue_rd_is_x & (bus.issue_rd == 5'(i));
            x_set[i] = bus.issue_valid & bus.issue_rd_is_x & (bus.issue_rd == 5'(i)) & (i != 0);
            v_clr[i] = pop & ~head.is_x & (head.addr == 5'(i));
            x_clr[i] = pop & head.is_x & (head.addr == 5'(i));
        end
    end

    // Clear before set so a re-issue racing the retiring write keeps the bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_en     <= 1'b0;
            prev_addr   <= '0;
            v_busy      <= '0;
            x_busy      <= '0;
            wb_overflow <= 1'b0;
        end else begin
            prev_en   <= cur_en;
            prev_addr <= bus.reg_wr_addr;
            v_busy    <= (v_busy & ~v_clr) | v_set;
            x_busy    <= (x_busy & ~x_clr) | x_set;
            if (capture & fifo_full & ~pop) wb_overflow <= 1'b1;
        end
    end

    assign bus.issue_stall = v_busy[bus.chk_vs1] | v_busy[bus.chk_vs2] | v_busy[bus.chk_vd]
                           | ((bus.chk_xs1 != 5'd0) & x_busy[bus.chk_xs1])
                           | fifo_full;
    assign bus.v_busy      = v_busy;
    assign bus.x_busy      = x_busy;
    assign bus.wb_overflow = wb_overflow;

endmodule

// File: tb/tb_carrd_wb_commit.sv
// Bench for carrd_wb_commit: queue-based reference model updated each clock,
// negedge monitor compares every DUT output against it.
module tb_carrd_wb_commit;
    import carrd_wb_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    carrd_wb_commit_if bus();

    carrd_wb_commit #(.DEPTH(DEPTH), .NREGS(32), .VLEN_W(512)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_vwr   = 0;
    int n_xwr   = 0;

    // Reference model: the pending-write queue and the busy sets.
    wb_entry_t   mq[$];
    logic        m_prev_en   = 1'b0;
    logic [4:0]  m_prev_addr = 5'd0;
    logic [31:0] m_vb        = 32'd0;
    logic [31:0] m_xb        = 32'd0;
    logic        m_ovf       = 1'b0;
    logic        m_pop;
    wb_entry_t   m_e;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_prev_en   = 1'b0;
            m_prev_addr = 5'd0;
            m_vb        = 32'd0;
            m_xb        = 32'd0;
            m_ovf       = 1'b0;
        end else begin
            m_pop = (mq.size() > 0) && (mq[0].is_x || bus.vrf_ready);
            if (m_pop) begin
                if (mq[0].is_x) m_xb[mq[0].addr] = 1'b0;
                else            m_vb[mq[0].addr] = 1'b0;
                void'(mq.pop_front());
            end
            if ((bus.v_reg_wr_en || bus.x_reg_wr_en) &&
                (!m_prev_en || bus.reg_wr_addr != m_prev_addr)) begin
                m_e.is_x = !bus.v_reg_wr_en;
                m_e.addr = bus.reg_wr_addr;
                m_e.data = {bus.reg_wr_data_4, bus.reg_wr_data_3, bus.reg_wr_data_2, bus.reg_wr_data};
                if (mq.size() < DEPTH) mq.push_back(m_e);
                else                   m_ovf = 1'b1;
            end
            if (bus.issue_valid) begin
                if (!bus.issue_rd_is_x)       m_vb[bus.issue_rd] = 1'b1;
                else if (bus.issue_rd != 5'd0) m_xb[bus.issue_rd] = 1'b1;
            end
            m_prev_en   = bus.v_reg_wr_en || bus.x_reg_wr_en;
            m_prev_addr = bus.reg_wr_addr;
        end
    end

    // Monitor: every cycle out of reset, the head of the model queue is the write the DUT must present.
    always @(negedge clk) begin
        if (!rst) begin
            logic exp_v, exp_x, exp_stall;
            exp_v = (mq.size() > 0) && !mq[0].is_x;
            exp_x = (mq.size() > 0) && mq[0].is_x;
            check("vrf_wr_en", bus.vrf_wr_en, exp_v);
            check("xrf_wr_en", bus.xrf_wr_en, exp_x);
            if (exp_v && bus.vrf_wr_en) begin
                check("vrf_wr_addr", bus.vrf_wr_addr, mq[0].addr);
                check("vrf_wr_data", bus.vrf_wr_data, mq[0].data);
            end
            if (exp_x && bus.xrf_wr_en) begin
                check("xrf_wr_addr", bus.xrf_wr_addr, mq[0].addr);
                check("xrf_wr_data", bus.xrf_wr_data, mq[0].data[31:0]);
            end
            exp_stall = m_vb[bus.chk_vs1] || m_vb[bus.chk_vs2] || m_vb[bus.chk_vd] ||
                        (bus.chk_xs1 != 5'd0 && m_xb[bus.chk_xs1]) || (mq.size() == DEPTH);
            check("issue_stall", bus.issue_stall, exp_stall);
            check("v_busy", bus.v_busy, m_vb);
            check("x_busy", bus.x_busy, m_xb);
            check("wb_overflow", bus.wb_overflow, m_ovf);
            if (bus.vrf_wr_en && bus.vrf_ready) n_vwr++;
            if (bus.xrf_wr_en) n_xwr++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.v_reg_wr_en   = 1'b0;
        bus.x_reg_wr_en   = 1'b0;
        bus.issue_valid   = 1'b0;
    endtask

    task automatic wb_event(input logic v, input logic x, input logic [4:0] a,
                            input logic [127:0] l0, input logic [127:0] l1,
                            input logic [127:0] l2, input logic [127:0] l3);
        bus.v_reg_wr_en   = v;
        bus.x_reg_wr_en   = x;
        bus.reg_wr_addr   = a;
        bus.reg_wr_data   = l0;
        bus.reg_wr_data_2 = l1;
        bus.reg_wr_data_3 = l2;
        bus.reg_wr_data_4 = l3;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        int snap;
        idle_inputs();
        wb_event(1'b0, 1'b0, 5'd0, '0, '0, '0, '0);
        bus.issue_rd      = 5'd0;
        bus.issue_rd_is_x = 1'b0;
        bus.chk_vs1       = 5'd0;
        bus.chk_vs2       = 5'd0;
        bus.chk_vd        = 5'd0;
        bus.chk_xs1       = 5'd0;
        bus.vrf_ready     = 1'b1;

        repeat (3) step();
        check("rst_vrf_wr_en", bus.vrf_wr_en, 1'b0);
        check("rst_xrf_wr_en", bus.xrf_wr_en, 1'b0);
        rst = 1'b0;
        step();
        check("reset_v_busy", bus.v_busy, 32'd0);
        check("reset_x_busy", bus.x_busy, 32'd0);
        check("reset_overflow", bus.wb_overflow, 1'b0);
        check("reset_stall", bus.issue_stall, 1'b0);

        // Held enable yields a single write.
        snap = n_vwr;
        wb_event(1'b1, 1'b0, 5'd3, 128'hA, 128'hB, 128'hC, 128'hD);
        step();
        check("hold_first_vrf_en", bus.vrf_wr_en, 1'b1);
        check("hold_first_data", bus.vrf_wr_data, {128'hD, 128'hC, 128'hB, 128'hA});
        repeat (4) step();
        idle_inputs();
        repeat (3) step();
        check("hold_single_write", n_vwr - snap, 1);

        // Fill with VRF stalled, overflow on the fifth event, then drain.
        bus.vrf_ready = 1'b0;
        for (int a = 1; a <= 5; a++) begin
            wb_event(1'b1, 1'b0, 5'(a), rnd128(), rnd128(), rnd128(), rnd128());
            step();
        end
        idle_inputs();
        check("full_stall", bus.issue_stall, 1'b1);
        check("overflow_set", bus.wb_overflow, 1'b1);
        snap = n_vwr;
        step();
        bus.vrf_ready = 1'b1;
        repeat (6) step();
        check("drain_count", n_vwr - snap, 4);

        // RAW on v7 until its write pops.
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.issue_rd_is_x = 1'b0;
        step();
        bus.issue_valid = 1'b0;
        bus.chk_vs1 = 5'd7;
        repeat (2) step();
        check("raw_stall", bus.issue_stall, 1'b1);
        wb_event(1'b1, 1'b0, 5'd7, rnd128(), rnd128(), rnd128(), rnd128());
        step();
        idle_inputs();
        check("raw_stall_until_pop", bus.issue_stall, 1'b1);
        step();
        check("raw_released", bus.issue_stall, 1'b0);
        check("raw_busy7_clear", bus.v_busy[7], 1'b0);
        bus.chk_vs1 = 5'd0;

        // Scalar write waits behind a stalled vector write.
        bus.vrf_ready = 1'b0;
        wb_event(1'b1, 1'b0, 5'd6, rnd128(), rnd128(), rnd128(), rnd128());
        step();
        wb_event(1'b0, 1'b1, 5'd9, 128'h0123_4567_89AB_CDEF_1111_2222_DEAD_BEEF, rnd128(), rnd128(), rnd128());
        step();
        idle_inputs();
        repeat (2) step();
        check("x_in_order_wait", bus.xrf_wr_en, 1'b0);
        snap = n_xwr;
        bus.vrf_ready = 1'b1;
        step();
        check("x_after_v", bus.xrf_wr_en, 1'b1);
        check("x_lane0_data", bus.xrf_wr_data, 32'hDEAD_BEEF);
        repeat (2) step();
        check("x_written_once", n_xwr - snap, 1);

        // Reset while entries are queued and busy bits are set.
        bus.vrf_ready = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd10; bus.issue_rd_is_x = 1'b0;
        step();
        bus.issue_rd = 5'd11; bus.issue_rd_is_x = 1'b1;
        step();
        bus.issue_valid = 1'b0;
        for (int a = 1; a <= 3; a++) begin
            wb_event(1'b1, 1'b0, 5'(a), rnd128(), rnd128(), rnd128(), rnd128());
            step();
        end
        idle_inputs();
        step();
        check("pre_rst_busy_x11", bus.x_busy[11], 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_vrf_en", bus.vrf_wr_en, 1'b0);
        check("rst_mid_xrf_en", bus.xrf_wr_en, 1'b0);
        check("rst_mid_v_busy", bus.v_busy, 32'd0);
        check("rst_mid_x_busy", bus.x_busy, 32'd0);
        step();
        rst = 1'b0;
        bus.vrf_ready = 1'b1;
        snap = n_vwr + n_xwr;
        repeat (5) step();
        check("no_writes_after_rst", n_vwr + n_xwr - snap, 0);

        // Issue to v2 in the cycle its write pops: the bit stays set.
        wb_event(1'b1, 1'b0, 5'd2, rnd128(), rnd128(), rnd128(), rnd128());
        step();
        idle_inputs();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd2; bus.issue_rd_is_x = 1'b0;
        step();
        bus.issue_valid = 1'b0;
        check("set_wins_v2", bus.v_busy[2], 1'b1);
        step();

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r >= 3 && r <= 6) begin
                int kind;
                kind = $urandom_range(0, 2);
                wb_event(kind != 1, kind != 0, 5'($urandom_range(0, 31)),
                         rnd128(), rnd128(), rnd128(), rnd128());
            end else if (r >= 7) begin
                bus.v_reg_wr_en = 1'b0;
                bus.x_reg_wr_en = 1'b0;
            end
            bus.issue_valid   = ($urandom_range(0, 3) == 0);
            bus.issue_rd      = 5'($urandom_range(0, 31));
            bus.issue_rd_is_x = 1'($urandom_range(0, 1));
            bus.chk_vs1       = 5'($urandom_range(0, 31));
            bus.chk_vs2       = 5'($urandom_range(0, 31));
            bus.chk_vd        = 5'($urandom_range(0, 31));
            bus.chk_xs1       = 5'($urandom_range(0, 31));
            bus.vrf_ready     = ($urandom_range(0, 2) != 0);
            step();
        end

        idle_inputs();
        bus.vrf_ready = 1'b1;
        repeat (10) step();
        check("final_vrf_idle", bus.vrf_wr_en, 1'b0);
        check("final_xrf_idle", bus.xrf_wr_en, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/carrd_wb_commit.md
Name: carrd_wb_commit

Overview:
Sits directly downstream of carrd_writeback, between the writeback stage and the vector and scalar register files. It captures each writeback event once, even though writeback enables are level signals that can stay high for several cycles. Captured events go into a small commit FIFO and are drained into the VRF (which can stall) or the XRF (which never stalls). The block also holds the destination-register scoreboard and raises the issue-stall signal for RAW and WAW hazards.

Parameters:
DEPTH, 4, commit FIFO entries (power of 2, ≥2)
NREGS, 32, registers per file (v and x)
VLEN_W, 512, full vector register width (4 lanes × 128)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
v_reg_wr_en  in  1  vector writeback enable from writeback stage
x_reg_wr_en  in  1  scalar writeback enable from writeback stage
reg_wr_addr  in  5  writeback destination
reg_wr_data  in  128  lane 0 data
reg_wr_data_2  in  128  lane 1 data
reg_wr_data_3  in  128  lane 2 data
reg_wr_data_4  in  128  lane 3 data
issue_valid  in  1  decode is issuing an instruction this cycle
issue_rd  in  5  destination of issuing instruction
issue_rd_is_x  in  1  destination is x register
chk_vs1, chk_vs2, chk_vd  in  5 each  vector operands of the instruction waiting to issue
chk_xs1  in  5  scalar operand of the instruction waiting to issue
vrf_ready  in  1  VRF accepts a write this cycle
vrf_wr_en  out  1  VRF write strobe
vrf_wr_addr  out  5  VRF write address
vrf_wr_data  out  512  {lane3,lane2,lane1,lane0}
xrf_wr_en  out  1  XRF write strobe
xrf_wr_addr  out  5  XRF write address
xrf_wr_data  out  32  lane 0 bits [31:0]
issue_stall  out  1  hazard on checked operands, or FIFO full
v_busy  out  32  vector scoreboard
x_busy  out  32  scalar scoreboard
wb_overflow  out  1  sticky: event dropped because FIFO full

Behaviour:
- Reset (async, rst=1): FIFO empty; pointers and count = 0; v_busy = x_busy = 0; wb_overflow = 0; internal prev_en/prev_addr = 0. All write strobes are 0 while reset is asserted. Reset mid-drain discards every queued entry.
- Event detection:
  - cur_en = v_reg_wr_en | x_reg_wr_en.
  - An event is captured when cur_en=1 and (prev_en=0 or reg_wr_addr≠prev_addr).
  - prev_en and prev_addr register every cycle.
  - If both enables are high, the vector write wins and the x write is ignored.
- Push: the entry {is_x, addr, 512-bit data} is written at the FIFO tail on the capture edge.
- Full handling:
  - Push at full with no pop in the same cycle: entry dropped, wb_overflow set (sticky until reset).
  - Push at full with a pop in the same cycle: both happen and count is unchanged.
- Drain: driven combinationally from the FIFO head when not empty.
  - Head is_x=0: vrf_wr_en=1; pop only when vrf_ready=1. Otherwise hold the head with outputs stable.
  - Head is_x=1: xrf_wr_en=1; pop the same cycle.
  - Latency: an event captured at edge N appears on vrf_wr_en/xrf_wr_en in cycle N+1 if the FIFO was empty. One write leaves per cycle at most.
- Scoreboard:
  - issue_valid sets busy[issue_rd] in the v_busy or x_busy file.
  - A pop clears busy[head.addr] in the matching file.
  - Same-cycle set and clear of the same bit: set wins.
  - Issue of x0 never sets x_busy[0].
- issue_stall (combinational) = v_busy[chk_vs1] | v_busy[chk_vs2] | v_busy[chk_vd] | (chk_xs1≠0 & x_busy[chk_xs1]) | full.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits. full = (count==DEPTH); empty = (count==0).
- Scoreboard counter width and the issue path assume one outstanding write per register. issue_stall enforces this because vd is checked.

Decomposition:
- Package carrd_wb_pkg:
  - wb_entry_t struct {is_x, addr[4:0], data[511:0]}
  - NUM_LANES=4, LANE_W=128
  - function lane_pack()
- Sub-module carrd_wb_fifo:
  - Generic synchronous FIFO of wb_entry_t with push, pop, full, empty and count.
  - Async reset.
- Detection, drain and scoreboard logic stay in the top level.

Test Plan:
- Hold v_reg_wr_en=1 for 5 cycles with addr=3 and data lanes 0xA..0xD. Required: exactly one vrf_wr_en pulse, addr 3, data {D,C,B,A}, one cycle after the capture edge.
- Set vrf_ready=0 and deliver 4 distinct vector events (addr 1..4), then a 5th event at addr 5. Required: issue_stall=1 once full, 5th event dropped, wb_overflow=1. Release vrf_ready: writes drain in order 1, 2, 3, 4.
- Issue rd=v7; then check chk_vs1=7. Required: issue_stall=1 until the v7 write pops, then 0 in the following cycle with v_busy[7]=0.
- Send an x write to addr 9 while the FIFO head is a vector write stalled by vrf_ready=0. Required: the x write waits behind it (in-order), and xrf_wr_data equals lane 0 [31:0] of its entry.
- Assert rst mid-drain with 3 entries queued and busy bits set. Required: all strobes 0 immediately, v_busy=x_busy=0, no writes after rst deasserts.
- Issue to v2 in the same cycle that the v2 write pops. Required: v_busy[2] stays 1.
